// File: rtl/lock_supervisor.sv
// lock_supervisor: supervises an external combination-lock FSM.
// Counts failed attempts, enforces a timed lockout after too many failures,
// and runs a two-pass password programming sequence that commits a new
// password only when both entries agree.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// NORMAL    | lock FSM enabled, failures counted, z+prog_req opens prog
// LOCKOUT   | lock FSM held in initialize until the lockout timer expires
// PROG1     | collecting first password entry into shadow A
// PROG2     | collecting confirmation entry into shadow B, then compare

module lock_supervisor #(
    parameter int                 NKEYS        = 4,
    parameter logic [2*NKEYS-1:0] DEFAULT_SEQ  = 8'b11_10_01_00,
    parameter int                 MAX_FAIL     = 3,
    parameter int                 LOCKOUT_CYC  = 250000000,
    parameter int                 PROG_TIMEOUT = 500000000
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [3:0]         i_key,
    input  logic               i_z,
    input  logic               i_err,
    input  logic               i_prog_req,
    output logic [2*NKEYS-1:0] o_ulseq,
    output logic               o_fsm_en,
    output logic [1:0]         o_fail_cnt,
    output logic               o_locked_out,
    output logic               o_prog_active,
    output logic               o_prog_done,
    output logic               o_prog_reject
);

    localparam int SW   = 2 * NKEYS;
    localparam int TMAX = (LOCKOUT_CYC > PROG_TIMEOUT) ? LOCKOUT_CYC : PROG_TIMEOUT;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int CW   = $clog2(NKEYS + 1);

    // Lockout counts down from LOCKOUT_CYC-1 to 0, so the state lasts LOCKOUT_CYC cycles.
    localparam logic [TW-1:0] LOCK_LOAD  = TW'(LOCKOUT_CYC - 1);
    localparam logic [TW-1:0] PROG_LIMIT = TW'(PROG_TIMEOUT - 1);
    localparam logic [TW-1:0] TIMER_ONE  = TW'(1);
    localparam logic [CW-1:0] LAST_DIGIT = CW'(NKEYS - 1);
    localparam logic [CW-1:0] CNT_SAT    = CW'(NKEYS);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [1:0]    FAIL_LAST  = 2'(MAX_FAIL - 1);
    localparam logic [1:0]    FAIL_MAX   = 2'(MAX_FAIL);

    typedef enum logic [1:0] {
        S_NORMAL  = 2'd0,
        S_LOCKOUT = 2'd1,
        S_PROG1   = 2'd2,
        S_PROG2   = 2'd3
    } state_t;

    state_t          r_state;
    logic [3:0]      r_key_prev;
    logic            r_z_prev;
    logic            r_err_prev;
    logic [TW-1:0]   r_timer;
    logic [CW-1:0]   r_digit_cnt;
    logic [SW-1:0]   r_shadow_a;
    logic [SW-1:0]   r_shadow_b;
    logic [SW-1:0]   r_ulseq;
    logic [1:0]      r_fail_cnt;

    logic            r_fsm_en;
    logic            r_locked_out;
    logic            r_prog_active;
    logic            r_prog_done;
    logic            r_prog_reject;

    state_t          w_state_next;
    logic [TW-1:0]   w_timer_next;
    logic [CW-1:0]   w_cnt_next;
    logic [SW-1:0]   w_a_next;
    logic [SW-1:0]   w_b_next;
    logic [SW-1:0]   w_ulseq_next;
    logic [1:0]      w_fail_next;
    logic            w_done;
    logic            w_reject;

    logic            w_z_evt;
    logic            w_err_evt;
    logic            w_key_valid;
    logic [1:0]      w_code;
    logic            w_press;
    logic [SW-1:0]   w_a_wr;
    logic [SW-1:0]   w_b_wr;
    logic [CW-1:0]   w_cnt_inc;

    logic            w_fsm_en_next;
    logic            w_locked_next;
    logic            w_prog_active_next;

    assign w_z_evt   = i_z & ~r_z_prev;
    assign w_err_evt = i_err & ~r_err_prev;
    assign w_press   = w_key_valid && (r_key_prev == 4'b1111);
    assign w_cnt_inc = (r_digit_cnt == CNT_SAT) ? r_digit_cnt : (r_digit_cnt + CNT_ONE);

    // Decode a single active-low button into its 2-bit code; chords are not valid.
    always_comb begin
        w_key_valid = 1'b1;
        w_code      = 2'b00;
        case (i_key)
            4'b1110: w_code = 2'b00;
            4'b1101: w_code = 2'b01;
            4'b1011: w_code = 2'b10;
            4'b0111: w_code = 2'b11;
            default: w_key_valid = 1'b0;
        endcase
    end

    // Insert the pressed code at the current digit position of each shadow.
    always_comb begin
        w_a_wr = r_shadow_a;
        w_b_wr = r_shadow_b;
        for (int i = 0; i < NKEYS; i++) begin
            if (r_digit_cnt == CW'(i)) begin
                w_a_wr[2*i +: 2] = w_code;
                w_b_wr[2*i +: 2] = w_code;
            end
        end
    end

    // Next-state and datapath update for the supervisor FSM.
    always_comb begin
        w_state_next = r_state;
        w_timer_next = r_timer;
        w_cnt_next   = r_digit_cnt;
        w_a_next     = r_shadow_a;
        w_b_next     = r_shadow_b;
        w_ulseq_next = r_ulseq;
        w_fail_next  = r_fail_cnt;
        w_done       = 1'b0;
        w_reject     = 1'b0;
        case (r_state)
            S_NORMAL: begin
                // An error wins over a simultaneous success; the z edge is dropped.
                if (w_err_evt) begin
                    if (r_fail_cnt == FAIL_LAST) begin
                        w_state_next = S_LOCKOUT;
                        w_timer_next = LOCK_LOAD;
                        w_fail_next  = FAIL_MAX;
                    end else begin
                        w_fail_next = r_fail_cnt + 2'd1;
                    end
                end else if (w_z_evt) begin
                    w_fail_next = 2'd0;
                    if (i_prog_req) begin
                        w_state_next = S_PROG1;
                        w_cnt_next   = '0;
                        w_timer_next = '0;
                        w_a_next     = '0;
                        w_b_next     = '0;
                    end
                end
            end
            S_LOCKOUT: begin
                if (r_timer == '0) begin
                    w_state_next = S_NORMAL;
                    w_fail_next  = 2'd0;
                end else begin
                    w_timer_next = r_timer - TIMER_ONE;
                end
            end
            S_PROG1: begin
                if (!i_prog_req) begin
                    w_reject     = 1'b1;
                    w_state_next = S_NORMAL;
                end else if (w_press) begin
                    w_a_next     = w_a_wr;
                    w_timer_next = '0;
                    if (r_digit_cnt == LAST_DIGIT) begin
                        w_state_next = S_PROG2;
                        w_cnt_next   = '0;
                    end else begin
                        w_cnt_next = w_cnt_inc;
                    end
                end else if (r_timer == PROG_LIMIT) begin
                    w_reject     = 1'b1;
                    w_state_next = S_NORMAL;
                end else begin
                    w_timer_next = r_timer + TIMER_ONE;
                end
            end
            S_PROG2: begin
                if (!i_prog_req) begin
                    w_reject     = 1'b1;
                    w_state_next = S_NORMAL;
                end else if (w_press) begin
                    w_b_next     = w_b_wr;
                    w_timer_next = '0;
                    if (r_digit_cnt == LAST_DIGIT) begin
                        // Compare including the digit being entered this cycle.
                        w_state_next = S_NORMAL;
                        w_cnt_next   = '0;
                        if (w_b_wr == r_shadow_a) begin
                            w_ulseq_next = r_shadow_a;
                            w_done       = 1'b1;
                        end else begin
                            w_reject = 1'b1;
                        end
                    end else begin
                        w_cnt_next = w_cnt_inc;
                    end
                end else if (r_timer == PROG_LIMIT) begin
                    w_reject     = 1'b1;
                    w_state_next = S_NORMAL;
                end else begin
                    w_timer_next = r_timer + TIMER_ONE;
                end
            end
            default: begin
                w_state_next = S_NORMAL;
            end
        endcase
    end

    // State, datapath and input-history registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_NORMAL;
            r_key_prev  <= 4'b1111;
            r_z_prev    <= 1'b0;
            r_err_prev  <= 1'b0;
            r_timer     <= '0;
            r_digit_cnt <= '0;
            r_shadow_a  <= '0;
            r_shadow_b  <= '0;
            r_ulseq     <= DEFAULT_SEQ;
            r_fail_cnt  <= 2'd0;
        end else begin
            r_state     <= w_state_next;
            r_key_prev  <= i_key;
            r_z_prev    <= i_z;
            r_err_prev  <= i_err;
            r_timer     <= w_timer_next;
            r_digit_cnt <= w_cnt_next;
            r_shadow_a  <= w_a_next;
            r_shadow_b  <= w_b_next;
            r_ulseq     <= w_ulseq_next;
            r_fail_cnt  <= w_fail_next;
        end
    end

    // Status outputs follow the state being entered so they line up with it.
    always_comb begin
        w_fsm_en_next      = (w_state_next == S_NORMAL);
        w_locked_next      = (w_state_next == S_LOCKOUT);
        w_prog_active_next = (w_state_next == S_PROG1) || (w_state_next == S_PROG2);
    end

    // Output registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_fsm_en      <= 1'b1;
            r_locked_out  <= 1'b0;
            r_prog_active <= 1'b0;
            r_prog_done   <= 1'b0;
            r_prog_reject <= 1'b0;
        end else begin
            r_fsm_en      <= w_fsm_en_next;
            r_locked_out  <= w_locked_next;
            r_prog_active <= w_prog_active_next;
            r_prog_done   <= w_done;
            r_prog_reject <= w_reject;
        end
    end

    assign o_ulseq       = r_ulseq;
    assign o_fsm_en      = r_fsm_en;
    assign o_fail_cnt    = r_fail_cnt;
    assign o_locked_out  = r_locked_out;
    assign o_prog_active = r_prog_active;
    assign o_prog_done   = r_prog_done;
    assign o_prog_reject = r_prog_reject;

endmodule

// File: tb/tb_lock_supervisor.sv
// Directed testbench for lock_supervisor with short lockout/timeout values.

module tb_lock_supervisor;

    localparam logic [7:0] DEF_SEQ = 8'b11_10_01_00;

    logic       i_clk = 1'b0;
    logic       i_reset;
    logic [3:0] i_key;
    logic       i_z;
    logic       i_err;
    logic       i_prog_req;
    logic [7:0] o_ulseq;
    logic       o_fsm_en;
    logic [1:0] o_fail_cnt;
    logic       o_locked_out;
    logic       o_prog_active;
    logic       o_prog_done;
    logic       o_prog_reject;

    int n_cmp = 0;
    int n_mis = 0;

    lock_supervisor #(
        .NKEYS(4),
        .DEFAULT_SEQ(DEF_SEQ),
        .MAX_FAIL(3),
        .LOCKOUT_CYC(20),
        .PROG_TIMEOUT(30)
    ) dut (
        .i_clk(i_clk),
        .i_reset(i_reset),
        .i_key(i_key),
        .i_z(i_z),
        .i_err(i_err),
        .i_prog_req(i_prog_req),
        .o_ulseq(o_ulseq),
        .o_fsm_en(o_fsm_en),
        .o_fail_cnt(o_fail_cnt),
        .o_locked_out(o_locked_out),
        .o_prog_active(o_prog_active),
        .o_prog_done(o_prog_done),
        .o_prog_reject(o_prog_reject)
    );

    always #5 i_clk = ~i_clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic key_down(input logic [1:0] code);
        i_key = ~(4'b0001 << code);
        tick();
    endtask

    task automatic key_up();
        i_key = 4'b1111;
        tick();
    endtask

    task automatic press(input logic [1:0] code);
        key_down(code);
        key_up();
    endtask

    task automatic err_pulse();
        i_err = 1'b1;
        tick();
        i_err = 1'b0;
        tick();
    endtask

    task automatic z_pulse();
        i_z = 1'b1;
        tick();
        i_z = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int locked_cycles;
        logic [1:0] seq_a [4];
        logic [1:0] seq_b [4];
        seq_a = '{2'b01, 2'b11, 2'b00, 2'b10};
        seq_b = '{2'b01, 2'b11, 2'b00, 2'b11};

        i_reset    = 1'b1;
        i_key      = 4'b1111;
        i_z        = 1'b0;
        i_err      = 1'b0;
        i_prog_req = 1'b0;
        tick();
        tick();
        i_reset = 1'b0;

        // Reset state
        check_val("rst_ulseq", o_ulseq, DEF_SEQ);
        check_val("rst_fsm_en", o_fsm_en, 1);
        check_val("rst_fail", o_fail_cnt, 0);
        check_val("rst_locked", o_locked_out, 0);
        check_val("rst_prog", {o_prog_active, o_prog_done, o_prog_reject}, 0);

        // Three failures lead to a 20-cycle lockout
        i_err = 1'b1; tick(); check_val("fail1", o_fail_cnt, 1); i_err = 1'b0; tick();
        i_err = 1'b1; tick(); check_val("fail2", o_fail_cnt, 2); i_err = 1'b0; tick();
        i_err = 1'b1; tick();
        check_val("fail3", o_fail_cnt, 3);
        check_val("lock_on", o_locked_out, 1);
        check_val("lock_fsm_en", o_fsm_en, 0);
        i_err = 1'b0;
        locked_cycles = 1;
        for (int n = 0; n < 40; n++) begin
            if (n == 3) i_err = 1'b1;
            if (n == 4) i_err = 1'b0;
            tick();
            if (!o_locked_out) break;
            locked_cycles++;
        end
        check_val("lock_len", locked_cycles, 20);
        check_val("lock_exit_fail", o_fail_cnt, 0);
        check_val("lock_exit_en", o_fsm_en, 1);

        // Two failures then success clears the count
        err_pulse();
        err_pulse();
        check_val("pre_z_fail", o_fail_cnt, 2);
        z_pulse();
        check_val("z_clear", o_fail_cnt, 0);
        check_val("z_nolock", o_locked_out, 0);
        check_val("z_noprog", o_prog_active, 0);
        err_pulse();
        check_val("after_z_fail", o_fail_cnt, 1);
        z_pulse();

        // Successful programming
        i_prog_req = 1'b1;
        i_z = 1'b1; tick();
        check_val("prog_enter", o_prog_active, 1);
        check_val("prog_fsm_en", o_fsm_en, 0);
        i_z = 1'b0; tick();
        for (int i = 0; i < 4; i++) press(seq_a[i]);
        check_val("prog2_active", o_prog_active, 1);
        for (int i = 0; i < 3; i++) press(seq_a[i]);
        key_down(seq_a[3]);
        check_val("commit_done", o_prog_done, 1);
        check_val("commit_rej", o_prog_reject, 0);
        check_val("commit_ulseq", o_ulseq, 8'b10_00_11_01);
        check_val("commit_idle", o_prog_active, 0);
        key_up();
        check_val("done_pulse", o_prog_done, 0);
        i_prog_req = 1'b0;

        // Mismatched confirmation
        do_reset();
        check_val("rst2_ulseq", o_ulseq, DEF_SEQ);
        i_prog_req = 1'b1;
        z_pulse();
        for (int i = 0; i < 4; i++) press(seq_a[i]);
        for (int i = 0; i < 3; i++) press(seq_b[i]);
        key_down(seq_b[3]);
        check_val("mm_reject", o_prog_reject, 1);
        check_val("mm_done", o_prog_done, 0);
        check_val("mm_ulseq", o_ulseq, DEF_SEQ);
        check_val("mm_idle", o_prog_active, 0);
        key_up();
        check_val("rej_pulse", o_prog_reject, 0);

        // Inactivity timeout in PROG1: reject 30 edges after the press edge
        z_pulse();
        check_val("to_enter", o_prog_active, 1);
        key_down(2'b10);
        key_up();
        for (int n = 0; n < 28; n++) tick();
        check_val("to_not_yet", o_prog_reject, 0);
        check_val("to_still_prog", o_prog_active, 1);
        tick();
        check_val("to_reject", o_prog_reject, 1);
        check_val("to_normal", o_fsm_en, 1);
        check_val("to_ulseq", o_ulseq, DEF_SEQ);

        // prog_req dropped in PROG2
        z_pulse();
        for (int i = 0; i < 4; i++) press(seq_a[i]);
        press(seq_a[0]);
        i_prog_req = 1'b0;
        tick();
        check_val("drop_reject", o_prog_reject, 1);
        check_val("drop_idle", o_prog_active, 0);
        check_val("drop_en", o_fsm_en, 1);
        check_val("drop_ulseq", o_ulseq, DEF_SEQ);

        // Reset mid-lockout
        err_pulse();
        err_pulse();
        err_pulse();
        tick(); tick(); tick();
        check_val("mid_lock", o_locked_out, 1);
        do_reset();
        check_val("rl_fsm_en", o_fsm_en, 1);
        check_val("rl_locked", o_locked_out, 0);
        check_val("rl_fail", o_fail_cnt, 0);
        check_val("rl_ulseq", o_ulseq, DEF_SEQ);

        // Reset mid-PROG2 discards the partial password
        i_prog_req = 1'b1;
        z_pulse();
        for (int i = 0; i < 4; i++) press(seq_a[i]);
        press(seq_a[0]);
        check_val("mid_prog2", o_prog_active, 1);
        do_reset();
        check_val("rp_fsm_en", o_fsm_en, 1);
        check_val("rp_prog", o_prog_active, 0);
        check_val("rp_ulseq", o_ulseq, DEF_SEQ);

        // Simultaneous z and err: error wins, no programming entry
        i_z   = 1'b1;
        i_err = 1'b1;
        tick();
        check_val("both_fail", o_fail_cnt, 1);
        check_val("both_noprog", o_prog_active, 0);
        i_z   = 1'b0;
        i_err = 1'b0;
        i_prog_req = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/lock_supervisor.md
LOCK_SUPERVISOR -- requirements
Module: lock_supervisor

Interface
REQ-001 Parameter NKEYS, default 4: password length in key presses; ulseq width is 2*NKEYS.
REQ-002 Parameter DEFAULT_SEQ, default 8'b11_10_01_00: password loaded at reset; width is 2*NKEYS.
REQ-003 Parameter MAX_FAIL, default 3: consecutive failed attempts that trigger lockout.
REQ-004 Parameter LOCKOUT_CYC, default 250000000: lockout duration in clk cycles.
REQ-005 Parameter PROG_TIMEOUT, default 500000000: programming inactivity limit in clk cycles.
REQ-006 clk  in  1  system clock; all logic on rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 key  in  4  active-low push buttons: 1110 = code 00, 1101 = 01, 1011 = 10, 0111 = 11, 1111 = released.
REQ-009 z  in  1  level from the lock FSM; high means a correct sequence was entered.
REQ-010 err  in  1  level from the lock FSM; high means the error display is active.
REQ-011 prog_req  in  1  programming-mode request switch.
REQ-012 ulseq  out  2*NKEYS  current password, driven to the lock FSM.
REQ-013 fsm_en  out  1  drives the lock FSM enable0; low holds that FSM in initialize.
REQ-014 fail_cnt  out  2  count of consecutive failed attempts.
REQ-015 locked_out  out  1  high while in LOCKOUT.
REQ-016 prog_active  out  1  high in PROG1 and PROG2.
REQ-017 prog_done  out  1  one-cycle pulse when a new password is committed.
REQ-018 prog_reject  out  1  one-cycle pulse when programming is aborted.

Function
REQ-019 All outputs shall be registered; every response appears one cycle after the sampled cause.
REQ-020 z and err shall be rising-edge detected against their registered previous values, giving z_evt and err_evt.
REQ-021 A press event shall occur when the registered previous key is 1111 and the current key is one of the four valid codes; any other multi-low pattern shall be ignored.
REQ-022 The block shall have states NORMAL, LOCKOUT, PROG1 and PROG2; fsm_en shall be 1 only in NORMAL.
REQ-023 In NORMAL, err_evt shall increment fail_cnt.
REQ-024 In NORMAL, when fail_cnt equals MAX_FAIL-1 on an err_evt, the block shall go to LOCKOUT, load the timer with LOCKOUT_CYC-1 and set fail_cnt to MAX_FAIL.
REQ-025 In NORMAL, z_evt shall clear fail_cnt; if prog_req is 1 in the same cycle, the block shall go to PROG1 and clear the digit count and inactivity timer.
REQ-026 If z_evt and err_evt occur in the same cycle, err_evt shall take priority and z_evt shall be discarded.
REQ-027 In LOCKOUT, the timer shall decrement every cycle and key, z and err shall be ignored.
REQ-028 In LOCKOUT, when the timer reaches 0 the block shall go to NORMAL and clear fail_cnt.
REQ-029 In PROG1, each press shall write its 2-bit code into shadow A at bits [2i+1:2i] (i = 0-based digit index), increment the digit count and clear the inactivity timer.
REQ-030 In PROG1, the NKEYS-th press shall move the block to PROG2 and clear the digit count.
REQ-031 PROG2 shall fill shadow B using the same rules as PROG1.
REQ-032 On the NKEYS-th press in PROG2: if B equals A, ulseq shall load A and prog_done shall pulse; otherwise prog_reject shall pulse; in both cases the block shall go to NORMAL.
REQ-033 In PROG1 or PROG2, prog_req low or the inactivity timer reaching PROG_TIMEOUT-1 shall pulse prog_reject and return the block to NORMAL with ulseq unchanged.
REQ-034 Shadow registers shall be cleared on every entry to PROG1; the digit count shall saturate at NKEYS.
REQ-035 ulseq shall change only on reset or a successful commit.

Reset
REQ-036 With reset high at a clock edge, the block shall enter NORMAL with ulseq=DEFAULT_SEQ, fsm_en=1, fail_cnt=0, all pulse and status outputs 0, and timers, shadows and edge-detect history cleared (key history 1111).
REQ-037 Reset shall override every state, including mid-lockout and mid-programming; a partially entered password shall be discarded.

Verification (with LOCKOUT_CYC=20 and PROG_TIMEOUT=30)
REQ-038 Three err pulses in NORMAL -> fail_cnt goes 1, 2, then 3; locked_out=1 and fsm_en=0 for exactly 20 cycles; then NORMAL with fail_cnt=0.
REQ-039 Two err pulses, then a z pulse -> fail_cnt=0 and no lockout; a third err pulse afterwards -> fail_cnt=1.
REQ-040 z pulse with prog_req=1, then keys 1101, 0111, 1110, 1011 entered twice -> prog_done pulses and ulseq=8'b10_00_11_01.
REQ-041 Second entry in PROG2 differs in its last digit -> prog_reject pulses and ulseq stays DEFAULT_SEQ.
REQ-042 Idle 30 cycles after one press in PROG1 -> prog_reject pulses and state is NORMAL; prog_req dropped mid-PROG2 -> same response.
REQ-043 Reset asserted mid-lockout and mid-PROG2 -> next cycle fsm_en=1, ulseq=DEFAULT_SEQ; z and err asserted in the same cycle -> fail_cnt increments.
